// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported, fixed-latency memory between an instruction-fetch
// port (read-only) and a data port (read/write), with an anti-starvation skip counter.
module mem_port_arbiter #(
  parameter int WORD_SIZE  = 16,
  parameter int LATENCY    = 2,
  parameter int SKIP_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_address,
  output logic                 i_done,
  output logic [WORD_SIZE-1:0] i_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_address,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 d_done,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [WORD_SIZE-1:0] mem_address,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic                 busy,
  output logic                 grant_d
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(LATENCY - 1);
  localparam logic [3:0] SKIP_MAX = 4'(SKIP_LIMIT);

  state_t     state;
  state_t     next_state;
  logic [3:0] cnt;
  logic [3:0] skip_cnt;
  logic       grant_we;
  logic       any_req;
  logic       win_d;

  // D normally wins a tie; I is forced once it has been skipped SKIP_LIMIT times.
  always_comb begin
    any_req = i_req | d_req;
    win_d   = d_req & ~(i_req & (skip_cnt == SKIP_MAX));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_req) next_state = BUSY;
      BUSY:    if (cnt == LAST_CNT) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    mem_read  = (state == BUSY) & ~grant_we;
    mem_write = (state == BUSY) & grant_we;
    i_done    = (state == DONE) & ~grant_d;
    d_done    = (state == DONE) & grant_d;
  end

  // Grant, address and write data are captured once so later request changes are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= 4'd0;
      skip_cnt    <= 4'd0;
      grant_d     <= 1'b0;
      grant_we    <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      i_rdata     <= '0;
      d_rdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            cnt      <= 4'd0;
            grant_d  <= win_d;
            grant_we <= win_d & d_we;
            if (win_d) begin
              mem_address <= d_address;
              mem_wdata   <= d_wdata;
              if (i_req && (skip_cnt != SKIP_MAX)) begin
                skip_cnt <= skip_cnt + 4'd1;
              end
            end else begin
              mem_address <= i_address;
              skip_cnt    <= 4'd0;
            end
          end
        end
        BUSY: begin
          cnt <= cnt + 4'd1;
          if ((cnt == LAST_CNT) && !grant_we) begin
            if (grant_d) begin
              d_rdata <= mem_rdata;
            end else begin
              i_rdata <= mem_rdata;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter: a transaction-level model
// predicts grants, strobe windows, done timing and read data from a reference memory.
module tb_mem_port_arbiter;

  localparam int W    = 16;
  localparam int LAT  = 2;
  localparam int SKIP = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          i_req, d_req, d_we;
  logic [W-1:0]  i_address, d_address, d_wdata;
  logic          i_done, d_done, mem_read, mem_write, busy, grant_d;
  logic [W-1:0]  i_rdata, d_rdata, mem_address, mem_wdata, mem_rdata;

  logic          i_req1, d_req1, d_we1;
  logic [W-1:0]  i_address1, d_address1, d_wdata1;
  logic          i_done1, d_done1, mem_read1, mem_write1, busy1, grant_d1;
  logic [W-1:0]  i_rdata1, d_rdata1, mem_address1, mem_wdata1, mem_rdata1;

  int            vectors = 0;
  int            errors  = 0;

  int            skip;
  logic [W-1:0]  ref_mem [256];
  logic [W-1:0]  exp_i, exp_d;

  logic [W-1:0]  mem_arr [256];
  logic          mem_loaded = 1'b0;
  logic [3:0]    scnt;

  mem_port_arbiter #(.WORD_SIZE(W), .LATENCY(LAT), .SKIP_LIMIT(SKIP)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_address(i_address), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_address(d_address), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .grant_d(grant_d)
  );

  mem_port_arbiter #(.WORD_SIZE(W), .LATENCY(1), .SKIP_LIMIT(SKIP)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req1), .i_address(i_address1), .i_done(i_done1), .i_rdata(i_rdata1),
    .d_req(d_req1), .d_we(d_we1), .d_address(d_address1), .d_wdata(d_wdata1),
    .d_done(d_done1), .d_rdata(d_rdata1),
    .mem_read(mem_read1), .mem_write(mem_write1), .mem_address(mem_address1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1),
    .busy(busy1), .grant_d(grant_d1)
  );

  always #5 clk = ~clk;

  // Memory model: data valid and writes committed only at the final latency edge.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scnt <= 4'd0;
      if (!mem_loaded) begin
        for (int i = 0; i < 256; i++) mem_arr[i] <= 16'(i * 40503 + 7);
        mem_loaded <= 1'b1;
      end
    end else if (mem_read || mem_write) begin
      if (scnt == 4'(LAT - 1)) begin
        scnt <= 4'd0;
        if (mem_write) mem_arr[mem_address[7:0]] <= mem_wdata;
      end else begin
        scnt <= scnt + 4'd1;
      end
    end else begin
      scnt <= 4'd0;
    end
  end

  always_comb begin
    mem_rdata  = (mem_read && scnt == 4'(LAT - 1)) ? mem_arr[mem_address[7:0]]
                                                   : ~mem_arr[mem_address[7:0]];
    mem_rdata1 = mem_arr[mem_address1[7:0]];
  end

  // One complete access, entered and left on the falling edge of an IDLE cycle.
  task automatic run_access(input bit perturb);
    bit           win_d, we;
    logic [W-1:0] addr, wd;
    vectors++;
    if ({busy, i_done, d_done} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL idle_flags got %b want 000", {busy, i_done, d_done});
    end
    if (!i_req && !d_req) return;
    win_d = d_req && !(i_req && skip == SKIP);
    we    = win_d && d_we;
    addr  = win_d ? d_address : i_address;
    wd    = d_wdata;
    if (!win_d) skip = 0;
    else if (i_req) skip = (skip < SKIP) ? skip + 1 : SKIP;
    @(posedge clk);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      if (perturb) begin
        if (win_d) begin
          d_address = 16'($urandom);
          d_wdata   = 16'($urandom);
          d_we      = 1'($urandom);
        end else begin
          i_address = 16'($urandom);
        end
      end
      vectors++;
      if ({busy, mem_read, mem_write, i_done, d_done, grant_d} !== {1'b1, !we, we, 2'b00, win_d}) begin
        errors++;
        $display("[TB] FAIL busy_flags cycle %0d got %b want %b", k,
                 {busy, mem_read, mem_write, i_done, d_done, grant_d}, {1'b1, !we, we, 2'b00, win_d});
      end
      vectors++;
      if (mem_address !== addr || (we && mem_wdata !== wd)) begin
        errors++;
        $display("[TB] FAIL mem_addr_data got %h/%h want %h/%h", mem_address, mem_wdata, addr, wd);
      end
    end
    if (we) ref_mem[addr[7:0]] = wd;
    else if (win_d) exp_d = ref_mem[addr[7:0]];
    else exp_i = ref_mem[addr[7:0]];
    @(negedge clk);
    vectors++;
    if ({busy, mem_read, mem_write, i_done, d_done} !== {3'b100, !win_d, win_d}) begin
      errors++;
      $display("[TB] FAIL done_flags got %b want %b",
               {busy, mem_read, mem_write, i_done, d_done}, {3'b100, !win_d, win_d});
    end
    vectors++;
    if (i_rdata !== exp_i || d_rdata !== exp_d) begin
      errors++;
      $display("[TB] FAIL rdata got %h/%h want %h/%h", i_rdata, d_rdata, exp_i, exp_d);
    end
    vectors++;
    if (dut.skip_cnt !== 4'(skip)) begin
      errors++;
      $display("[TB] FAIL skip_cnt got %0d want %0d", dut.skip_cnt, skip);
    end
    if (win_d) d_req = 1'b0;
    else i_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    vectors++;
    if ({busy, mem_read, mem_write, i_done, d_done, grant_d} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags got %b want 000000", {busy, mem_read, mem_write, i_done, d_done, grant_d});
    end
    vectors++;
    if ({mem_address, mem_wdata, i_rdata, d_rdata} !== 64'b0) begin
      errors++;
      $display("[TB] FAIL reset_data got %h want 0", {mem_address, mem_wdata, i_rdata, d_rdata});
    end
    vectors++;
    if (dut.skip_cnt !== 4'd0) begin
      errors++;
      $display("[TB] FAIL reset_skip got %0d want 0", dut.skip_cnt);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({busy, i_done, d_done} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL idle_no_req got %b want 000", {busy, i_done, d_done});
    end
  endtask

  task automatic test_i_read();
    d_req = 1'b1; d_we = 1'b1; d_address = 16'h0023; d_wdata = 16'h6000;
    run_access(1'b0);
    i_req = 1'b1; i_address = 16'h0023;
    run_access(1'b0);
    vectors++;
    if (i_rdata !== 16'h6000) begin
      errors++;
      $display("[TB] FAIL i_read_value got %h want 6000", i_rdata);
    end
  endtask

  task automatic test_d_write_read();
    d_req = 1'b1; d_we = 1'b1; d_address = 16'h0010; d_wdata = 16'hBEEF;
    run_access(1'b0);
    d_req = 1'b1; d_we = 1'b0; d_address = 16'h0010; d_wdata = 16'h0000;
    run_access(1'b0);
    vectors++;
    if (d_rdata !== 16'hBEEF) begin
      errors++;
      $display("[TB] FAIL d_read_back got %h want beef", d_rdata);
    end
  endtask

  task automatic test_simultaneous();
    i_req = 1'b1; i_address = 16'h0010;
    d_req = 1'b1; d_we = 1'b0; d_address = 16'h0023;
    run_access(1'b0);
    run_access(1'b0);
  endtask

  task automatic test_skip_limit();
    i_req = 1'b1; i_address = 16'($urandom);
    for (int s = 0; s < 5; s++) begin
      d_req = 1'b1; d_we = 1'($urandom); d_address = 16'($urandom); d_wdata = 16'($urandom);
      run_access(1'b0);
      vectors++;
      if (grant_d !== (s < 4)) begin
        errors++;
        $display("[TB] FAIL skip_grant %0d got %b want %b", s, grant_d, (s < 4));
      end
    end
    run_access(1'b0);
  endtask

  task automatic test_reset_abort();
    logic [7:0]   a;
    logic [W-1:0] old;
    a   = 8'($urandom);
    old = ref_mem[a];
    d_req = 1'b1; d_we = 1'b1; d_address = {8'h00, a}; d_wdata = ~old;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (mem_write !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_strobe got %b want 1", mem_write);
    end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if ({busy, mem_read, mem_write, i_done, d_done, grant_d} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL abort_flags got %b want 000000", {busy, mem_read, mem_write, i_done, d_done, grant_d});
    end
    skip = 0; exp_i = '0; exp_d = '0;
    @(negedge clk);
    d_req = 1'b0; d_we = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || mem_arr[a] !== old) begin
      errors++;
      $display("[TB] FAIL abort_mem got busy=%b word=%h want busy=0 word=%h", busy, mem_arr[a], old);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      if (!i_req && $urandom_range(0, 1) == 1) begin
        i_req = 1'b1; i_address = 16'($urandom);
      end
      if (!d_req && ($urandom_range(0, 1) == 1 || !i_req)) begin
        d_req = 1'b1; d_we = 1'($urandom); d_address = 16'($urandom); d_wdata = 16'($urandom);
      end
      run_access(1'b1);
    end
    while (i_req || d_req) run_access(1'b0);
  endtask

  task automatic test_latency1();
    logic [7:0] a;
    a = 8'($urandom);
    i_req1 = 1'b1; i_address1 = {8'h00, a};
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({busy1, mem_read1, mem_write1, i_done1} !== 4'b1100) begin
      errors++;
      $display("[TB] FAIL lat1_busy got %b want 1100", {busy1, mem_read1, mem_write1, i_done1});
    end
    @(negedge clk);
    vectors++;
    if ({mem_read1, i_done1, d_done1} !== 3'b010 || i_rdata1 !== ref_mem[a]) begin
      errors++;
      $display("[TB] FAIL lat1_done got %b/%h want 010/%h", {mem_read1, i_done1, d_done1}, i_rdata1, ref_mem[a]);
    end
    i_req1 = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lat1_idle got %b want 0", busy1);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_address = '0; d_address = '0; d_wdata = '0;
    i_req1 = 1'b0; d_req1 = 1'b0; d_we1 = 1'b0;
    i_address1 = '0; d_address1 = '0; d_wdata1 = '0;
    skip = 0; exp_i = '0; exp_d = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'(i * 40503 + 7);
    test_reset();
    test_i_read();
    test_d_write_read();
    test_simultaneous();
    test_skip_limit();
    test_reset_abort();
    test_random();
    test_latency1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
